pipe_exec_ctrl: RTL and testbench

- Execution controller for the 5-stage MIPS pipeline.
- Drives the shared `enable` of every pipeline latch (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC, plus a soft flush.
- Sequences free-run, single-step, stop, and halt-drain so a HALT instruction retires through WB before the core freezes.
- Sits between the debug unit (command source) and the datapath; exposes a cycle counter for the debug dump.

---
 rtl/pipe_exec_ctrl_pkg.sv | 25 ++
 rtl/pipe_exec_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_exec_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_exec_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline execution controller.
// Command and state values are also decoded by the debug unit.
package pipe_exec_ctrl_pkg;

  localparam int CTRL_STATE_BITS  = 3;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  typedef enum logic [CTRL_STATE_BITS-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4,
    ST_FLUSH  = 3'd5
  } state_e;

endpackage

// File: rtl/pipe_exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Also intended for stall and branch statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Run/step/stop/halt-drain sequencer driving the shared pipeline latch enable.
// state | meaning: IDLE frozen, RUN free-run, STEP one cycle, DRAIN retire HALT, HALTED done, FLUSH clear.
module pipe_exec_ctrl
  import pipe_exec_ctrl_pkg::*;
#(
  parameter int CNT_BITS     = 32,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cmd_valid,
  input  logic [1:0]                 i_cmd,
  output logic                       o_cmd_ready,
  input  logic                       i_halt,
  output logic                       o_pipe_enable,
  output logic                       o_pipe_flush,
  output logic [CTRL_STATE_BITS-1:0] o_state,
  output logic [CNT_BITS-1:0]        o_cycle_count,
  output logic                       o_done
);

  localparam int DRAIN_W   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int FLUSH_LEN = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES : 1;
  localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);

  state_e               state;
  logic                 halt_pending;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 cmd_fire;

  assign cmd_fire = i_cmd_valid && o_cmd_ready;
  assign o_state  = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      o_pipe_enable <= 1'b0;
      o_pipe_flush  <= 1'b0;
      o_done        <= 1'b0;
      o_cmd_ready   <= 1'b1;
      halt_pending  <= 1'b0;
      drain_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (i_cmd)
              CMD_RUN: begin
                state         <= halt_pending ? ST_DRAIN : ST_RUN;
                o_pipe_enable <= 1'b1;
                o_cmd_ready   <= !halt_pending;
              end
              CMD_STEP: begin
                state         <= ST_STEP;
                o_pipe_enable <= 1'b1;
                o_cmd_ready   <= 1'b0;
              end
              CMD_FLUSH: begin
                state        <= ST_FLUSH;
                o_pipe_flush <= 1'b1;
                o_cmd_ready  <= 1'b0;
                flush_cnt    <= FLUSH_W'(FLUSH_LEN);
              end
              CMD_STOP: ;
            endcase
          end
        end
        ST_RUN: begin
          // A HALT in flight must retire even if STOP arrives in the same cycle.
          if (i_halt) begin
            if (DRAIN_CYCLES == 0) begin
              state         <= ST_HALTED;
              o_pipe_enable <= 1'b0;
              o_done        <= 1'b1;
            end else begin
              state       <= ST_DRAIN;
              drain_cnt   <= DRAIN_W'(DRAIN_CYCLES);
              o_cmd_ready <= 1'b0;
            end
          end else if (cmd_fire && (i_cmd == CMD_STOP)) begin
            state         <= ST_IDLE;
            o_pipe_enable <= 1'b0;
          end
        end
        ST_STEP: begin
          o_pipe_enable <= 1'b0;
          o_cmd_ready   <= 1'b1;
          state         <= ST_IDLE;
          if (halt_pending) begin
            if (drain_cnt <= DRAIN_W'(1)) begin
              state     <= ST_HALTED;
              o_done    <= 1'b1;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end else if (i_halt) begin
            if (DRAIN_CYCLES == 0) begin
              state  <= ST_HALTED;
              o_done <= 1'b1;
            end else begin
              halt_pending <= 1'b1;
              drain_cnt    <= DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt <= DRAIN_W'(1)) begin
            state         <= ST_HALTED;
            o_pipe_enable <= 1'b0;
            o_done        <= 1'b1;
            o_cmd_ready   <= 1'b1;
            drain_cnt     <= '0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HALTED: begin
          if (cmd_fire && (i_cmd == CMD_FLUSH)) begin
            state        <= ST_FLUSH;
            o_pipe_flush <= 1'b1;
            o_cmd_ready  <= 1'b0;
            flush_cnt    <= FLUSH_W'(FLUSH_LEN);
          end
        end
        ST_FLUSH: begin
          halt_pending <= 1'b0;
          drain_cnt    <= '0;
          if (flush_cnt <= FLUSH_W'(1)) begin
            state        <= ST_IDLE;
            o_pipe_flush <= 1'b0;
            o_cmd_ready  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          o_pipe_enable <= 1'b0;
          o_pipe_flush  <= 1'b0;
          o_cmd_ready   <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_BITS)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (o_pipe_enable),
    .clr   (state == ST_FLUSH),
    .count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Directed bench for pipe_exec_ctrl; a CNT_BITS=4 twin shares the inputs for saturation.
module tb_pipe_exec_ctrl;
  import pipe_exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd = 2'b00;
  logic        i_halt = 1'b0;

  logic        o_cmd_ready, o_pipe_enable, o_pipe_flush, o_done;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;

  logic        r4, en4, fl4, dn4;
  logic [2:0]  st4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;
  int en_total = 0;
  int flush_total = 0;
  int done_total = 0;
  int overlap_total = 0;

  pipe_exec_ctrl dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt(i_halt), .o_pipe_enable(o_pipe_enable),
    .o_pipe_flush(o_pipe_flush), .o_state(o_state), .o_cycle_count(o_cycle_count),
    .o_done(o_done)
  );

  pipe_exec_ctrl #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(r4), .i_halt(i_halt), .o_pipe_enable(en4),
    .o_pipe_flush(fl4), .o_state(st4), .o_cycle_count(cnt4),
    .o_done(dn4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_pipe_enable) en_total++;
    if (o_pipe_flush) flush_total++;
    if (o_done) done_total++;
    if (o_pipe_enable && o_pipe_flush) overlap_total++;
  end

  // Presents a command at a negedge and returns 1ns after the accepting posedge.
  task automatic send_cmd(input logic [1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    while (!o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL cmd_accept_timeout cmd=%0d ready=%0b required=1", c, o_cmd_ready);
    end
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    checks++; if (o_pipe_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%0b exp=0", o_pipe_enable); end
    checks++; if (o_pipe_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", o_pipe_flush); end
    checks++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_cycle_count); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", o_done); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_cmd_ready); end
    rst = 1'b1;
  endtask

  task automatic test_run_stop();
    int en0, dn0;
    send_cmd(CMD_RUN);
    en0 = en_total; dn0 = done_total;
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL run_state got=%0d exp=1", o_state); end
    checks++; if (o_pipe_enable !== 1'b1) begin errors++; $display("FAIL run_enable got=%0b exp=1", o_pipe_enable); end
    repeat (9) @(negedge clk);
    send_cmd(CMD_STOP);
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL stop_state got=%0d exp=0", o_state); end
    checks++; if (o_pipe_enable !== 1'b0) begin errors++; $display("FAIL stop_enable got=%0b exp=0", o_pipe_enable); end
    checks++; if (o_cycle_count !== 32'd10) begin errors++; $display("FAIL run_count got=%0d exp=10", o_cycle_count); end
    checks++; if (en_total - en0 !== 10) begin errors++; $display("FAIL run_en_cycles got=%0d exp=10", en_total - en0); end
    checks++; if (done_total - dn0 !== 0) begin errors++; $display("FAIL run_done_pulses got=%0d exp=0", done_total - dn0); end
  endtask

  task automatic test_halt_drain();
    int en0, dn0;
    send_cmd(CMD_RUN);
    en0 = en_total; dn0 = done_total;
    repeat (5) @(negedge clk);
    i_halt = 1'b1;
    @(posedge clk); #1;
    i_halt = 1'b0;
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL halt_drain_state got=%0d exp=3", o_state); end
    checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got=%0b exp=0", o_cmd_ready); end
    repeat (3) @(posedge clk); #1;
    checks++; if (o_pipe_enable !== 1'b1 || o_state !== 3'd3) begin errors++; $display("FAIL drain_last_cycle en=%0b st=%0d exp en=1 st=3", o_pipe_enable, o_state); end
    @(posedge clk); #1;
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL halted_state got=%0d exp=4", o_state); end
    checks++; if (o_pipe_enable !== 1'b0) begin errors++; $display("FAIL halted_enable got=%0b exp=0", o_pipe_enable); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL halted_done got=%0b exp=1", o_done); end
    checks++; if (o_cycle_count !== 32'd9) begin errors++; $display("FAIL halt_count got=%0d exp=9", o_cycle_count); end
    checks++; if (en_total - en0 !== 9) begin errors++; $display("FAIL halt_en_cycles got=%0d exp=9", en_total - en0); end
    @(posedge clk); #1;
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%0b exp=0", o_done); end
    send_cmd(CMD_STEP);
    send_cmd(CMD_RUN);
    send_cmd(CMD_STOP);
    @(posedge clk); #1;
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL halted_sticky got=%0d exp=4", o_state); end
    checks++; if (o_pipe_enable !== 1'b0) begin errors++; $display("FAIL halted_sticky_en got=%0b exp=0", o_pipe_enable); end
    checks++; if (o_cycle_count !== 32'd9) begin errors++; $display("FAIL halted_count_hold got=%0d exp=9", o_cycle_count); end
    checks++; if (done_total - dn0 !== 1) begin errors++; $display("FAIL done_pulses got=%0d exp=1", done_total - dn0); end
  endtask

  task automatic test_flush();
    int fl0;
    send_cmd(CMD_FLUSH);
    fl0 = flush_total;
    checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL flush_state got=%0d exp=5", o_state); end
    checks++; if (o_pipe_flush !== 1'b1 || o_pipe_enable !== 1'b0) begin errors++; $display("FAIL flush_outputs fl=%0b en=%0b exp fl=1 en=0", o_pipe_flush, o_pipe_enable); end
    checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", o_cmd_ready); end
    @(posedge clk); #1;
    checks++; if (o_pipe_flush !== 1'b1) begin errors++; $display("FAIL flush_second_cycle got=%0b exp=1", o_pipe_flush); end
    checks++; if (o_cycle_count !== 32'd0) begin errors++; $display("FAIL flush_count_clear got=%0d exp=0", o_cycle_count); end
    @(posedge clk); #1;
    checks++; if (o_state !== 3'd0 || o_pipe_flush !== 1'b0) begin errors++; $display("FAIL flush_exit st=%0d fl=%0b exp st=0 fl=0", o_state, o_pipe_flush); end
    checks++; if (flush_total - fl0 !== 2) begin errors++; $display("FAIL flush_cycles got=%0d exp=2", flush_total - fl0); end
    send_cmd(CMD_RUN);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL post_flush_run got=%0d exp=1", o_state); end
    send_cmd(CMD_STOP);
  endtask

  task automatic test_step();
    int en0;
    en0 = en_total;
    for (int k = 1; k <= 7; k++) begin
      send_cmd(CMD_STEP);
      checks++; if (o_state !== 3'd2 || o_pipe_enable !== 1'b1 || o_cmd_ready !== 1'b0) begin
        errors++; $display("FAIL step_active k=%0d st=%0d en=%0b rdy=%0b exp st=2 en=1 rdy=0", k, o_state, o_pipe_enable, o_cmd_ready);
      end
      if (k == 3) i_halt = 1'b1;
      @(posedge clk); #1;
      i_halt = 1'b0;
      if (k < 7) begin
        checks++; if (o_state !== 3'd0 || o_pipe_enable !== 1'b0) begin
          errors++; $display("FAIL step_return k=%0d st=%0d en=%0b exp st=0 en=0", k, o_state, o_pipe_enable);
        end
      end else begin
        checks++; if (o_state !== 3'd4 || o_done !== 1'b1) begin
          errors++; $display("FAIL step_halted st=%0d done=%0b exp st=4 done=1", o_state, o_done);
        end
      end
    end
    checks++; if (o_cycle_count !== 32'd7) begin errors++; $display("FAIL step_count got=%0d exp=7", o_cycle_count); end
    checks++; if (en_total - en0 !== 7) begin errors++; $display("FAIL step_en_cycles got=%0d exp=7", en_total - en0); end
  endtask

  task automatic test_halt_stop();
    int en0;
    send_cmd(CMD_RUN);
    en0 = en_total;
    repeat (3) @(negedge clk);
    i_halt = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd = CMD_STOP;
    @(posedge clk); #1;
    i_halt = 1'b0;
    i_cmd_valid = 1'b0;
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL halt_beats_stop got=%0d exp=3", o_state); end
    repeat (3) @(posedge clk); #1;
    checks++; if (o_state !== 3'd3 || o_pipe_enable !== 1'b1) begin errors++; $display("FAIL halt_stop_drain st=%0d en=%0b exp st=3 en=1", o_state, o_pipe_enable); end
    @(posedge clk); #1;
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL halt_stop_halted got=%0d exp=4", o_state); end
    checks++; if (o_cycle_count !== 32'd7) begin errors++; $display("FAIL halt_stop_count got=%0d exp=7", o_cycle_count); end
    checks++; if (en_total - en0 !== 7) begin errors++; $display("FAIL halt_stop_en_cycles got=%0d exp=7", en_total - en0); end
  endtask

  task automatic test_reset_mid_drain();
    send_cmd(CMD_RUN);
    i_halt = 1'b1;
    @(posedge clk); #1;
    i_halt = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL mid_drain_state got=%0d exp=3", o_state); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_state !== 3'd0 || o_pipe_enable !== 1'b0 || o_pipe_flush !== 1'b0 || o_done !== 1'b0 || o_cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_mid_drain st=%0d en=%0b fl=%0b dn=%0b cnt=%0d exp all 0", o_state, o_pipe_enable, o_pipe_flush, o_done, o_cycle_count);
    end
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    send_cmd(CMD_RUN);
    repeat (20) @(posedge clk); #1;
    checks++; if (o_cycle_count !== 32'd20) begin errors++; $display("FAIL wide_count got=%0d exp=20", o_cycle_count); end
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_count got=%0d exp=15", cnt4); end
    checks++; if (st4 !== 3'd1 || en4 !== 1'b1 || fl4 !== 1'b0 || r4 !== 1'b1 || dn4 !== 1'b0) begin
      errors++; $display("FAIL narrow_run st=%0d en=%0b fl=%0b rdy=%0b dn=%0b exp 1 1 0 1 0", st4, en4, fl4, r4, dn4);
    end
    send_cmd(CMD_STOP);
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", cnt4); end
    checks++; if (o_cycle_count !== 32'd21) begin errors++; $display("FAIL wide_count_final got=%0d exp=21", o_cycle_count); end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    do_reset();
    test_halt_drain();
    test_flush();
    do_reset();
    test_step();
    do_reset();
    test_halt_stop();
    do_reset();
    test_reset_mid_drain();
    test_saturation();
    checks++; if (overlap_total !== 0) begin errors++; $display("FAIL enable_flush_overlap got=%0d exp=0", overlap_total); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
